// File: rtl/aidan_mcnay_operand_loader_pkg.sv
// Shared constants and FSM encoding for the operand loader.
// Also used by the prime core and the testbench.
package aidan_mcnay_operand_loader_pkg;

    localparam int NIBBLE_W  = 4;
    localparam int OPERAND_W = 16;
    localparam int NUM_NIB   = OPERAND_W / NIBBLE_W;
    localparam int CNT_W     = $clog2(NUM_NIB);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

endpackage

// File: rtl/aidan_mcnay_operand_loader_if.sv
// Operand handshake between the loader (master) and the prime core (slave).
interface aidan_mcnay_operand_loader_if;
    import aidan_mcnay_operand_loader_pkg::*;

    logic [OPERAND_W-1:0] operand;
    logic                 operand_val;
    logic                 operand_rdy;

    modport master (
        output operand,
        output operand_val,
        input  operand_rdy
    );

    modport slave (
        input  operand,
        input  operand_val,
        output operand_rdy
    );

endinterface

// File: rtl/aidan_mcnay_nibble_shifter.sv
// Shift-in register: each load pushes din into the LSBs.
// The oldest chunk ends up most significant.
module aidan_mcnay_nibble_shifter #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= {q[OUT_W-IN_W-1:0], din};
        end
    end

endmodule

// File: rtl/aidan_mcnay_operand_loader.sv
// Assembles 16-bit operands from strobed nibbles.
// Hands each operand to the prime core over valid/ready.
module aidan_mcnay_operand_loader
    import aidan_mcnay_operand_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NIBBLE_W-1:0] nibble_in,
    input  logic                strobe_pulse,
    aidan_mcnay_operand_loader_if.master op,
    output logic [CNT_W-1:0]    nib_count,
    output logic                overrun
);

    state_t               state;
    logic [NIBBLE_W-1:0]  nib_d1;
    logic                 val_q;
    logic                 xfer;
    logic                 load;
    logic [OPERAND_W-1:0] shreg;

    // A pulse in FULL is only taken if the core drains us in that cycle.
    assign xfer = (state == FULL) & val_q & op.operand_rdy;
    assign load = strobe_pulse & ((state == COLLECT) | xfer);

    aidan_mcnay_nibble_shifter #(
        .IN_W  (NIBBLE_W),
        .OUT_W (OPERAND_W)
    ) u_shifter (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .din  (nib_d1),
        .q    (shreg)
    );

    assign op.operand     = shreg;
    assign op.operand_val = val_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            val_q     <= 1'b0;
            nib_count <= '0;
            overrun   <= 1'b0;
            nib_d1    <= '0;
        end else begin
            // Matches the detector's one-register pulse lag.
            nib_d1 <= nibble_in;
            unique case (state)
                COLLECT: begin
                    if (strobe_pulse) begin
                        if (nib_count == CNT_W'(NUM_NIB - 1)) begin
                            state     <= FULL;
                            val_q     <= 1'b1;
                            nib_count <= '0;
                        end else begin
                            nib_count <= nib_count + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (xfer) begin
                        state     <= COLLECT;
                        val_q     <= 1'b0;
                        nib_count <= strobe_pulse ? CNT_W'(1) : '0;
                    end else if (strobe_pulse) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aidan_mcnay_operand_loader.sv
// Directed bench for the operand loader.
// Tables drive plain loads; sequences cover the handshake corners.
module tb_aidan_mcnay_operand_loader;
    import aidan_mcnay_operand_loader_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] nibble_in = 4'h0;
    logic       dir_pulse = 1'b0;
    logic       strobe_pin = 1'b0;
    logic       s1;
    logic       det_pulse;
    logic       strobe_pulse;
    logic [1:0] nib_count;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    aidan_mcnay_operand_loader_if bus ();

    aidan_mcnay_operand_loader dut (
        .clk          (clk),
        .rst          (rst),
        .nibble_in    (nibble_in),
        .strobe_pulse (strobe_pulse),
        .op           (bus),
        .nib_count    (nib_count),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Model of the upstream change detector: one register of lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= 1'b0;
            det_pulse <= 1'b0;
        end else begin
            s1        <= strobe_pin;
            det_pulse <= strobe_pin ^ s1;
        end
    end

    assign strobe_pulse = dir_pulse | det_pulse;

    typedef struct {
        logic [3:0][3:0] nib;
        logic [15:0]     exp_op;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] n);
        nibble_in = n;
        dir_pulse = 1'b0;
        tick();
        dir_pulse = 1'b1;
        tick();
        dir_pulse = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0].nib = {4'hA, 4'hB, 4'hC, 4'hD}; vecs[0].exp_op = 16'hABCD;
        vecs[1].nib = {4'h0, 4'h0, 4'h0, 4'h0}; vecs[1].exp_op = 16'h0000;
        vecs[2].nib = {4'hF, 4'hF, 4'hF, 4'hF}; vecs[2].exp_op = 16'hFFFF;
        vecs[3].nib = {4'h5, 4'hA, 4'h3, 4'hC}; vecs[3].exp_op = 16'h5A3C;

        bus.operand_rdy = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_operand", 32'(bus.operand), 0);
        chk("rst_val", 32'(bus.operand_val), 0);
        chk("rst_count", 32'(nib_count), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst = 1'b0;

        // Plain loads, core always ready.
        bus.operand_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                send(vecs[i].nib[3-k]);
                if (k < 3) chk("vec_count", 32'(nib_count), 32'(k + 1));
            end
            chk("vec_operand", 32'(bus.operand), 32'(vecs[i].exp_op));
            chk("vec_val", 32'(bus.operand_val), 1);
            chk("vec_count0", 32'(nib_count), 0);
            chk("vec_overrun", 32'(overrun), 0);
            tick();
            chk("vec_val_drop", 32'(bus.operand_val), 0);
        end

        // Backpressure and overrun.
        bus.operand_rdy = 1'b0;
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        chk("bp_operand", 32'(bus.operand), 32'h1234);
        chk("bp_val", 32'(bus.operand_val), 1);
        tick(); tick(); tick();
        chk("bp_val_hold", 32'(bus.operand_val), 1);
        send(4'h9);
        chk("bp_overrun", 32'(overrun), 1);
        chk("bp_operand_kept", 32'(bus.operand), 32'h1234);
        chk("bp_val_kept", 32'(bus.operand_val), 1);
        chk("bp_count", 32'(nib_count), 0);
        bus.operand_rdy = 1'b1;
        tick();
        chk("bp_val_drop", 32'(bus.operand_val), 0);
        chk("bp_overrun_sticky", 32'(overrun), 1);
        chk("bp_operand_after", 32'(bus.operand), 32'h1234);
        bus.operand_rdy = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("bp_overrun_clr", 32'(overrun), 0);

        // Pulse and transfer in the same cycle.
        send(4'hF); send(4'hF); send(4'hF); send(4'hF);
        chk("sim_full", 32'(bus.operand_val), 1);
        nibble_in = 4'h7;
        tick();
        dir_pulse = 1'b1;
        bus.operand_rdy = 1'b1;
        tick();
        dir_pulse = 1'b0;
        bus.operand_rdy = 1'b0;
        chk("sim_val", 32'(bus.operand_val), 0);
        chk("sim_count", 32'(nib_count), 1);
        chk("sim_overrun", 32'(overrun), 0);
        chk("sim_operand", 32'(bus.operand), 32'hFFF7);
        send(4'h0); send(4'h0); send(4'h1);
        chk("sim_next_op", 32'(bus.operand), 32'h7001);
        chk("sim_next_val", 32'(bus.operand_val), 1);
        bus.operand_rdy = 1'b1;
        tick();
        bus.operand_rdy = 1'b0;
        chk("sim_drain", 32'(bus.operand_val), 0);

        // Reset in the middle of an operand.
        send(4'h3); send(4'h3);
        chk("mid_count2", 32'(nib_count), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_count0", 32'(nib_count), 0);
        chk("mid_operand0", 32'(bus.operand), 0);
        send(4'h0); send(4'h0); send(4'h0); send(4'h2);
        chk("mid_operand", 32'(bus.operand), 32'h0002);
        chk("mid_val", 32'(bus.operand_val), 1);
        bus.operand_rdy = 1'b1;
        tick();
        bus.operand_rdy = 1'b0;

        // Alignment through the detector model.
        send(4'h0); send(4'h0); send(4'h0);
        nibble_in = 4'h3;
        tick(); tick();
        nibble_in = 4'h5;
        strobe_pin = ~strobe_pin;
        tick();
        nibble_in = 4'h3;
        chk("aln_pending", 32'(bus.operand_val), 0);
        tick();
        chk("aln_val", 32'(bus.operand_val), 1);
        chk("aln_operand", 32'(bus.operand), 32'h0005);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
